// File: rtl/sort_net_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sort_net_pipe
// Purpose  : Fully pipelined bitonic sorting network. Each beat carries N
//            lanes of DATA_W bits and its own sort direction. One vector can
//            enter per clock under valid/ready flow control. The sorted
//            vector leaves S = L*(L+1)/2 register stages later, where
//            L = log2(N).
// Ports    :
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   input vector valid
//   in_ready   out  block accepts the input vector this cycle
//   in_desc    in   direction of this beat (0 = ascending, 1 = descending)
//   in_data    in   N lanes; lane i = in_data[i*DATA_W +: DATA_W]
//   out_valid  out  sorted vector valid
//   out_ready  in   downstream accepts the output vector
//   out_desc   out  direction the output beat was sorted with
//   out_data   out  sorted lanes; lane 0 = min (asc) or max (desc)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sort_net_pipe #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_desc,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_desc,
  output logic [N*DATA_W-1:0] out_data
);

  localparam int L  = $clog2(N);
  localparam int S  = (L * (L + 1)) / 2;
  localparam int NW = N * DATA_W;

  generate
    if ((N < 4) || (N > 16) || ((N & (N - 1)) != 0)) begin : g_bad_n
      $error("sort_net_pipe: N must be a power of two in the range 4..16");
    end
  endgenerate

  // Stage registers: one compare-exchange column feeds each of them.
  logic [NW-1:0] r_data [S];
  logic [S-1:0]  r_desc;
  logic [S-1:0]  r_valid;

  // Per-stage column inputs and outputs, flattened stage by stage.
  logic [S*NW-1:0] w_in_data;
  logic [S*NW-1:0] w_col;
  logic [S-1:0]    w_in_desc;
  logic [S-1:0]    w_in_valid;
  logic            w_adv;

  // A single global enable: the whole pipe moves unless the output beat
  // is being held for the downstream consumer.
  assign w_adv    = !r_valid[S-1] || out_ready;
  assign in_ready = w_adv;

  // Stage 0 takes the input port; every later stage takes its predecessor.
  assign w_in_data[NW-1:0] = in_data;
  assign w_in_desc         = {r_desc[S-2:0], in_desc};
  assign w_in_valid        = {r_valid[S-2:0], in_valid};

  generate
    for (genvar s = 1; s < S; s++) begin : g_link
      assign w_in_data[s*NW +: NW] = r_data[s-1];
    end
  endgenerate

  // Bitonic network. Phase p builds sorted runs of 2^(p+1) lanes. Step j of
  // phase p compares lanes a distance 2^(p-j) apart. Inner phases alternate
  // direction per run so that the last phase always sees a bitonic sequence.
  // The last phase is a plain merge, so flipping its direction with the
  // beat's desc bit is enough to produce either order.
  generate
    for (genvar p = 0; p < L; p++) begin : g_phase
      for (genvar j = 0; j <= p; j++) begin : g_step
        localparam int SI = (p * (p + 1)) / 2 + j;
        localparam int D  = 1 << (p - j);
        for (genvar i = 0; i < N; i++) begin : g_lane
          if ((i & D) == 0) begin : g_cmp
            localparam bit BASE_DESC = (((i >> (p + 1)) & 1) != 0);
            logic [DATA_W-1:0] w_a;
            logic [DATA_W-1:0] w_b;
            logic              w_a_gt_b;
            logic              w_b_gt_a;
            logic              w_dir;
            logic              w_swap;

            assign w_a = w_in_data[SI*NW + i*DATA_W +: DATA_W];
            assign w_b = w_in_data[SI*NW + (i+D)*DATA_W +: DATA_W];

            if (SIGNED) begin : g_signed
              assign w_a_gt_b = $signed(w_a) > $signed(w_b);
              assign w_b_gt_a = $signed(w_b) > $signed(w_a);
            end else begin : g_unsigned
              assign w_a_gt_b = w_a > w_b;
              assign w_b_gt_a = w_b > w_a;
            end

            if (p == L - 1) begin : g_final
              assign w_dir = BASE_DESC ^ w_in_desc[SI];
            end else begin : g_inner
              assign w_dir = BASE_DESC;
            end

            // Strict compares: equal values stay where they are.
            assign w_swap = w_dir ? w_b_gt_a : w_a_gt_b;

            assign w_col[SI*NW + i*DATA_W +: DATA_W]     = w_swap ? w_b : w_a;
            assign w_col[SI*NW + (i+D)*DATA_W +: DATA_W] = w_swap ? w_a : w_b;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < S; s++) begin
        r_data[s] <= '0;
      end
      r_desc  <= '0;
      r_valid <= '0;
    end else if (w_adv) begin
      for (int s = 0; s < S; s++) begin
        r_data[s] <= w_col[s*NW +: NW];
      end
      r_desc  <= w_in_desc;
      r_valid <= w_in_valid;
    end
  end

  assign out_valid = r_valid[S-1];
  assign out_desc  = r_desc[S-1];
  assign out_data  = r_data[S-1];

endmodule
`default_nettype wire

// File: tb/tb_sort_net_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_net_pipe
// Purpose  : Self-checking bench for sort_net_pipe. It drives three
//            instances from shared stimulus:
//              0: N=8 signed
//              1: N=8 unsigned
//              2: N=4 unsigned (low four lanes)
//            A sorting model and per-instance scoreboards check every output
//            handshake. Directed beats pin literal results and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_net_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_desc;
  logic         out_ready;
  logic [127:0] in_data;

  logic         ir0, ov0, odsc0;
  logic         ir1, ov1, odsc1;
  logic         ir2, ov2, odsc2;
  logic [127:0] od0, od1;
  logic [63:0]  od2;

  logic         ir   [3];
  logic         ov   [3];
  logic         odsc [3];
  logic [127:0] od   [3];

  assign ir[0] = ir0;  assign ov[0] = ov0;  assign odsc[0] = odsc0;  assign od[0] = od0;
  assign ir[1] = ir1;  assign ov[1] = ov1;  assign odsc[1] = odsc1;  assign od[1] = od1;
  assign ir[2] = ir2;  assign ov[2] = ov2;  assign odsc[2] = odsc2;  assign od[2] = {64'd0, od2};

  int n_of   [3] = '{8, 8, 4};
  bit sgn_of [3] = '{1'b1, 1'b0, 1'b0};
  int s_of   [3] = '{6, 6, 3};

  always #5 clk = ~clk;

  sort_net_pipe #(.DATA_W(16), .N(8), .SIGNED(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_desc(in_desc),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_desc(odsc0),
    .out_data(od0));

  sort_net_pipe #(.DATA_W(16), .N(8), .SIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_desc(in_desc),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_desc(odsc1),
    .out_data(od1));

  sort_net_pipe #(.DATA_W(16), .N(4), .SIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_desc(in_desc),
    .in_data(in_data[63:0]), .out_valid(ov2), .out_ready(out_ready), .out_desc(odsc2),
    .out_data(od2));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [127:0] d;
    logic         desc;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  task automatic chk(input string name, input int k, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, got, exp, $time);
    end
  endtask

  // Reference: sort lane values numerically, then lay them out in the
  // requested direction.
  function automatic logic [127:0] model_sort(input logic [127:0] d, input int n,
                                               input bit sgn, input bit desc);
    longint v [16];
    longint t;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (sgn) v[i] = longint'($signed(d[i*16 +: 16]));
      else     v[i] = longint'(d[i*16 +: 16]);
    end
    for (int a = 0; a < n - 1; a++) begin
      for (int b = 0; b < n - 1 - a; b++) begin
        if (v[b] > v[b+1]) begin
          t = v[b]; v[b] = v[b+1]; v[b+1] = t;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      t = v[desc ? (n - 1 - i) : i];
      r[i*16 +: 16] = t[15:0];
    end
    return r;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input beat_t b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic qpop(input int k, output beat_t b);
    case (k)
      0:       b = q0.pop_front();
      1:       b = q1.pop_front();
      default: b = q2.pop_front();
    endcase
  endtask

  function automatic logic [127:0] rand_data(input int mode);
    logic [127:0] r;
    logic [15:0]  lane;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       lane = 16'($urandom_range(0, 3));
        1: begin
          case ($urandom_range(0, 3))
            0:       lane = 16'h8000;
            1:       lane = 16'h7FFF;
            2:       lane = 16'hFFFF;
            default: lane = 16'h0000;
          endcase
        end
        default: lane = 16'($urandom);
      endcase
      r[i*16 +: 16] = lane;
    end
    return r;
  endfunction

  // Scoreboard / protocol monitor. It samples at the falling edge and
  // anticipates the handshakes that occur on the next rising edge.
  bit           stall_prev [3];
  logic [127:0] hold_d     [3];
  logic         hold_desc  [3];
  beat_t        mb;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) stall_prev[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready_rule", k, ir[k], !ov[k] || out_ready);
        if (stall_prev[k]) begin
          chk("hold_valid", k, ov[k], 1'b1);
          chk("hold_data", k, od[k], hold_d[k]);
          chk("hold_desc", k, odsc[k], hold_desc[k]);
        end
        if (in_valid && ir[k]) begin
          mb.d    = model_sort(in_data, n_of[k], sgn_of[k], in_desc);
          mb.desc = in_desc;
          qpush(k, mb);
        end
        if (ov[k] && out_ready) begin
          if (qsize(k) == 0) begin
            chk("unexpected_output", k, 128'd1, 128'd0);
          end else begin
            qpop(k, mb);
            chk("sorted_data", k, od[k], mb.d);
            chk("sorted_desc", k, odsc[k], mb.desc);
          end
        end
        stall_prev[k] = ov[k] && !out_ready;
        hold_d[k]     = od[k];
        hold_desc[k]  = odsc[k];
      end
    end
  end

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks the exact cycle the output appears and pins
  // the sorted result to hand-computed literals.
  task automatic run_single(input logic [127:0] d, input bit desc,
                            input logic [127:0] e0, input logic [127:0] e1,
                            input logic [127:0] e2);
    logic [127:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_desc = desc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("valid_timing", k, ov[k], (m == s_of[k] - 1));
        if (ov[k]) begin
          chk("literal_data", k, od[k], e[k]);
          chk("literal_desc", k, odsc[k], desc);
        end
      end
    end
  endtask

  logic [127:0] t1_in, t1_e8, t1_e4;
  logic [127:0] t2_in, t2_es, t2_eu, t2_e4;
  bit   [5:0]   pat;
  int           pos0 [3];
  int           pos2 [3];
  int           cnt0, cnt2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_desc = 1'b0; out_ready = 1'b1; in_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("reset_valid", k, ov[k], 1'b0);
      chk("reset_data", k, od[k], 128'd0);
      chk("reset_desc", k, odsc[k], 1'b0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("reset_in_ready", k, ir[k], 1'b1);

    // Ascending, mixed values (low lanes 54,70,1,0).
    t1_in = {16'd1000, 16'd9, 16'd2, 16'd300, 16'd0, 16'd1, 16'd70, 16'd54};
    t1_e8 = {16'd1000, 16'd300, 16'd70, 16'd54, 16'd9, 16'd2, 16'd1, 16'd0};
    t1_e4 = {64'd0, 16'd70, 16'd54, 16'd1, 16'd0};
    run_single(t1_in, 1'b0, t1_e8, t1_e8, t1_e4);

    // Descending, lanes -3,7,0,-128,5,5,127,-1.
    t2_in = {16'hFFFF, 16'd127, 16'd5, 16'd5, 16'hFF80, 16'd0, 16'd7, 16'hFFFD};
    t2_es = {16'hFF80, 16'hFFFD, 16'hFFFF, 16'd0, 16'd5, 16'd5, 16'd7, 16'd127};
    t2_eu = {16'd0, 16'd5, 16'd5, 16'd7, 16'd127, 16'hFF80, 16'hFFFD, 16'hFFFF};
    t2_e4 = {64'd0, 16'd0, 16'd7, 16'hFF80, 16'hFFFD};
    run_single(t2_in, 1'b1, t2_es, t2_eu, t2_e4);

    // Back-to-back streaming with alternating direction.
    for (int b = 0; b < 20; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = rand_data(b % 3); in_desc = b[0]; out_ready = 1'b1;
      chk("stream_in_ready", 0, ir[0], 1'b1);
    end
    drain(12);

    // Backpressure: fill, then stall five cycles with input still offered.
    for (int b = 0; b < 10; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = rand_data(2); in_desc = 1'($urandom);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = rand_data(2); in_desc = 1'($urandom);
      @(negedge clk);
      chk("stall_in_ready", 0, ir[0], 1'b0);
    end
    drain(12);

    // Bubbles: in_valid pattern 1,0,0,1,0,1.
    pat = 6'b101001;
    cnt0 = 0; cnt2 = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 6) ? pat[c] : 1'b0;
      in_data = rand_data(2); in_desc = 1'($urandom);
      @(negedge clk);
      if (ov[0]) begin if (cnt0 < 3) pos0[cnt0] = c; cnt0++; end
      if (ov[2]) begin if (cnt2 < 3) pos2[cnt2] = c; cnt2++; end
    end
    chk("bubble_count", 0, cnt0, 3);
    chk("bubble_count", 2, cnt2, 3);
    if (cnt0 == 3) begin
      chk("bubble_pos0", 0, pos0[0], 6);
      chk("bubble_pos1", 0, pos0[1], 9);
      chk("bubble_pos2", 0, pos0[2], 11);
    end
    if (cnt2 == 3) begin
      chk("bubble_pos0", 2, pos2[0], 3);
      chk("bubble_pos1", 2, pos2[1], 6);
      chk("bubble_pos2", 2, pos2[2], 8);
    end
    drain(4);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_desc   = 1'($urandom);
      in_data   = rand_data($urandom_range(0, 2));
    end
    drain(14);

    // Asynchronous reset with four beats in flight.
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = rand_data(2); in_desc = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midreset_valid", k, ov[k], 1'b0);
      chk("midreset_data", k, od[k], 128'd0);
    end
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("postreset_in_ready", k, ir[k], 1'b1);
    drain(10);
    run_single(t1_in, 1'b0, t1_e8, t1_e8, t1_e4);
    drain(4);

    for (int k = 0; k < 3; k++) chk("scoreboard_empty", k, qsize(k), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
